vjtag_dr_engine: RTL and testbench
==================================

// Module: vjtag_dr_engine
// PURPOSE
//  Parametrised user-side data-register engine behind the virtual JTAG hub.
//  - Decodes an IR_W-bit instruction into N_CH capture/update data registers plus bypass.
//  - Shifts DR_W-bit scans LSB-first and reports status through ir_out on Capture-IR.
//  - Hands completed scans to fabric logic via a valid/ack handshake.
//  - Runs on the hub's tck, which is wired to clk_i.
// PARAMETERS
//  IR_W   4   instruction width; >=2; codes 0..N_CH-1 select channels, all others bypass
//  N_CH   4   number of data-register channels; 1..2**IR_W-1
//  DR_W   32  data-register width per channel; >=2
//  CNT_W  derived localparam = $clog2(DR_W+1); shifted-bit counter width
// PORTS
//  clk_i       in   1          scan clock (hub tck)
//  rst_i       in   1          asynchronous reset, active-high
//  tdi_i       in   1          hub tdi
//  tdo_o       out  1          hub tdo
//  ir_in_i     in   IR_W       hub ir_in
//  ir_out_o    out  IR_W       hub ir_out, status word
//  vs_cdr_i    in   1          virtual Capture-DR
//  vs_sdr_i    in   1          virtual Shift-DR
//  vs_udr_i    in   1          virtual Update-DR
//  vs_cir_i    in   1          virtual Capture-IR
//  vs_uir_i    in   1          virtual Update-IR
//  cap_data_i  in   N_CH*DR_W  per-channel capture values; channel k at [k*DR_W +: DR_W]
//  upd_data_o  out  DR_W       updated scan data
//  upd_ch_o    out  IR_W       channel of upd_data_o
//  upd_vld_o   out  1          update valid; held until ack
//  upd_ack_i   in   1          fabric consumed update
// BEHAVIOUR
//  Reset: all registers cleared asynchronously, including an in-progress scan.
//   Reset values: tdo_o=0, ir_out_o=0, upd_data_o=0, upd_ch_o=0, upd_vld_o=0; ir_q=bypass code (all ones).
//  IR: on vs_uir_i, ir_q<=ir_in_i. Channel is active when ir_q<N_CH; otherwise bypass.
//  State strobes: priority CDR>SDR>UDR>CIR>UIR when more than one is asserted.
//  Scan FSM {IDLE, CAP, SHIFT}:
//   - any state + vs_cdr_i -> CAP: shreg<=cap_data[ch] (bypass bit<=0), bitcnt<=0.
//   - CAP/SHIFT + vs_sdr_i -> SHIFT: shreg<={tdi_i,shreg[DR_W-1:1]} (bypass: byp<=tdi_i).
//     bitcnt increments and saturates at DR_W.
//   - CAP/SHIFT + vs_udr_i -> IDLE, with update check below.
//   - vs_sdr_i/vs_udr_i while IDLE is ignored; UDR in IDLE sets short_err.
//  tdo_o: registered; next value = shreg[0] after the CAP/SHIFT update (bypass: byp). Latency 1 clk.
//  Update check on UDR:
//   - bypass: no update.
//   - bitcnt<DR_W: set short_err; no update.
//   - otherwise: last DR_W bits are taken; longer scans are legal, excess flows out tdo.
//   - Accepted update: upd_data_o<=shreg, upd_ch_o<=ir_q, upd_vld_o<=1.
//   - If upd_vld_o=1 and upd_ack_i=0: set overrun; drop new data; held outputs unchanged.
//   - upd_ack_i with upd_vld_o=1 clears valid. Ack and new UDR in the same clk: new update accepted, no overrun.
//  Status on vs_cir_i: ir_out_o<={zero-ext, short_err, overrun, upd_vld_o} (bits 2:0; IR_W=2 drops short_err).
//   - short_err and overrun are sticky; cleared in the cycle they are captured.
//   - A set event in that same cycle wins, so the flag stays 1.
//  ir_out_o holds between CIR strobes.
// STRUCTURE
//  Package vjtag_pkg:
//   - scan FSM enum; status bit indices ST_VLD=0, ST_OVR=1, ST_SHORT=2
//   - function bypass_code(IR_W) returning all ones
//  Sub-module vjtag_shift_reg: DR_W shift register with load, shift, saturating bit counter.
//  Top: IR latch, channel mux, FSM, update/handshake and status flags.
// TESTING
//  1. DR_W=32, ir=1, cap[1]=0xA5A5_0F0F, CDR+32 SDR tdi=0x1234_5678 LSB-first, UDR.
//     -> tdo stream = 0xA5A5_0F0F LSB-first; upd_vld_o=1, data 0x1234_5678, ch 1.
//  2. Scan 16 bits then UDR -> no upd_vld_o; next CIR gives ir_out[2]=1; second CIR gives ir_out[2]=0.
//  3. Two full scans, no ack -> first data held; CIR gives ir_out=0b011.
//     Ack with third UDR in same clk -> third accepted, overrun stays 0.
//  4. ir=0xF (bypass), CDR, SDR tdi=1,0,1 -> tdo=0,1,0 one-bit delayed; UDR gives no update.
//  5. Assert rst_i mid-shift (bit 10) -> all outputs 0 immediately, ir_q=bypass; next UDR in IDLE sets short_err.
//  6. Scan 40 bits on ch 0 -> update holds last 32 bits shifted; first 8 tdi bits appear on tdo after capture data.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG data-register engine.
package vjtag_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CAP   = 2'd1,
    S_SHIFT = 2'd2
  } scan_state_e;

  localparam int ST_VLD   = 0;
  localparam int ST_OVR   = 1;
  localparam int ST_SHORT = 2;

  function automatic int unsigned bypass_code(input int unsigned ir_w);
    return (32'd1 << ir_w) - 32'd1;
  endfunction

endpackage

// File: rtl/vjtag_shift_reg.sv
// DR_W-bit LSB-first scan shift register with a bit counter that saturates at DR_W.
module vjtag_shift_reg #(
  parameter int DR_W  = 32,
  parameter int CNT_W = $clog2(DR_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DR_W-1:0]   load_data,
  input  logic              tdi,
  output logic [DR_W-1:0]   shreg,
  output logic [CNT_W-1:0]  bitcnt
);

  logic [DR_W-1:0]  shreg_r;
  logic [CNT_W-1:0] bitcnt_r;

  // Capture load, LSB-first shift and saturating shifted-bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r  <= '0;
      bitcnt_r <= '0;
    end else if (load) begin
      shreg_r  <= load_data;
      bitcnt_r <= '0;
    end else if (shift) begin
      shreg_r <= {tdi, shreg_r[DR_W-1:1]};
      if (bitcnt_r != CNT_W'(DR_W)) begin
        bitcnt_r <= bitcnt_r + CNT_W'(1);
      end
    end
  end

  assign shreg  = shreg_r;
  assign bitcnt = bitcnt_r;

endmodule

// File: rtl/vjtag_dr_engine.sv
// User-side data-register engine behind the virtual JTAG hub: IR decode,
// capture/shift/update of N_CH channels plus bypass, and a valid/ack update port.
module vjtag_dr_engine
  import vjtag_pkg::*;
#(
  parameter int IR_W = 4,
  parameter int N_CH = 4,
  parameter int DR_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  input  logic [IR_W-1:0]      ir_in_i,
  output logic [IR_W-1:0]      ir_out_o,
  input  logic                 vs_cdr_i,
  input  logic                 vs_sdr_i,
  input  logic                 vs_udr_i,
  input  logic                 vs_cir_i,
  input  logic                 vs_uir_i,
  input  logic [N_CH*DR_W-1:0] cap_data_i,
  output logic [DR_W-1:0]      upd_data_o,
  output logic [IR_W-1:0]      upd_ch_o,
  output logic                 upd_vld_o,
  input  logic                 upd_ack_i
);

  localparam int CNT_W = $clog2(DR_W + 1);

  scan_state_e      state_r;
  logic [IR_W-1:0]  ir_q_r;
  logic [IR_W-1:0]  ir_out_r;
  logic [DR_W-1:0]  upd_data_r;
  logic [IR_W-1:0]  upd_ch_r;
  logic             upd_vld_r;
  logic             tdo_r;
  logic             short_err_r;
  logic             overrun_r;

  logic             cdr_s, sdr_s, udr_s, cir_s, uir_s;
  logic             active_s, in_scan_s, full_s;
  logic             shift_s, accept_s, short_set_s, ovr_set_s;
  logic [DR_W-1:0]  cap_sel_s;
  logic [DR_W-1:0]  shreg_s;
  logic [CNT_W-1:0] bitcnt_s;
  logic [2:0]       flags_s;
  logic [IR_W-1:0]  status_s;

  // Strobe priority, channel select and update-check decisions.
  always_comb begin
    cdr_s = vs_cdr_i;
    sdr_s = vs_sdr_i & ~vs_cdr_i;
    udr_s = vs_udr_i & ~vs_cdr_i & ~vs_sdr_i;
    cir_s = vs_cir_i & ~vs_cdr_i & ~vs_sdr_i & ~vs_udr_i;
    uir_s = vs_uir_i & ~vs_cdr_i & ~vs_sdr_i & ~vs_udr_i & ~vs_cir_i;

    active_s  = (ir_q_r < IR_W'(N_CH));
    in_scan_s = (state_r != S_IDLE);
    full_s    = (bitcnt_s == CNT_W'(DR_W));

    cap_sel_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      cap_sel_s = (ir_q_r == IR_W'(k)) ? cap_data_i[k*DR_W +: DR_W] : cap_sel_s;
    end

    shift_s     = sdr_s & in_scan_s & active_s;
    short_set_s = udr_s & (~in_scan_s | (active_s & ~full_s));
    accept_s    = udr_s & in_scan_s & active_s & full_s & (~upd_vld_r | upd_ack_i);
    ovr_set_s   = udr_s & in_scan_s & active_s & full_s & upd_vld_r & ~upd_ack_i;

    flags_s           = 3'b000;
    flags_s[ST_VLD]   = upd_vld_r;
    flags_s[ST_OVR]   = overrun_r;
    flags_s[ST_SHORT] = short_err_r;
    // Narrow IR widths silently drop the upper flag bits.
    status_s = IR_W'(flags_s);
  end

  vjtag_shift_reg #(
    .DR_W  (DR_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (cdr_s),
    .shift     (shift_s),
    .load_data (cap_sel_s),
    .tdi       (tdi_i),
    .shreg     (shreg_s),
    .bitcnt    (bitcnt_s)
  );

  // Scan FSM, registered tdo, IR latch, update handshake and sticky status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      ir_q_r      <= IR_W'(bypass_code(IR_W));
      ir_out_r    <= '0;
      upd_data_r  <= '0;
      upd_ch_r    <= '0;
      upd_vld_r   <= 1'b0;
      tdo_r       <= 1'b0;
      short_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (cdr_s) begin
        state_r <= S_CAP;
        tdo_r   <= cap_sel_s[0];
      end else begin
        case (state_r)
          S_CAP, S_SHIFT: begin
            if (sdr_s) begin
              state_r <= S_SHIFT;
              // Bypass is a one-bit register, so tdo simply follows tdi one clock late.
              tdo_r   <= active_s ? shreg_s[1] : tdi_i;
            end else if (udr_s) begin
              state_r <= S_IDLE;
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end

      if (accept_s) begin
        upd_data_r <= shreg_s;
        upd_ch_r   <= ir_q_r;
        upd_vld_r  <= 1'b1;
      end else if (upd_ack_i) begin
        upd_vld_r <= 1'b0;
      end

      short_err_r <= short_set_s | (short_err_r & ~cir_s);
      overrun_r   <= ovr_set_s | (overrun_r & ~cir_s);

      if (cir_s) begin
        ir_out_r <= status_s;
      end
      if (uir_s) begin
        ir_q_r <= ir_in_i;
      end
    end
  end

  assign tdo_o      = tdo_r;
  assign ir_out_o   = ir_out_r;
  assign upd_data_o = upd_data_r;
  assign upd_ch_o   = upd_ch_r;
  assign upd_vld_o  = upd_vld_r;

endmodule

// File: tb/tb_vjtag_dr_engine.sv
// Directed self-checking bench for vjtag_dr_engine (IR_W=4, N_CH=4, DR_W=32).
module tb_vjtag_dr_engine;

  localparam int IR_W = 4;
  localparam int N_CH = 4;
  localparam int DR_W = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tdi = 1'b0;
  logic                 tdo;
  logic [IR_W-1:0]      ir_in = 4'h0;
  logic [IR_W-1:0]      ir_out;
  logic                 vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0;
  logic                 vs_cir = 1'b0, vs_uir = 1'b0;
  logic [N_CH*DR_W-1:0] cap_data;
  logic [DR_W-1:0]      upd_data;
  logic [IR_W-1:0]      upd_ch;
  logic                 upd_vld;
  logic                 upd_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] seen;

  vjtag_dr_engine #(.IR_W(IR_W), .N_CH(N_CH), .DR_W(DR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tdi_i      (tdi),
    .tdo_o      (tdo),
    .ir_in_i    (ir_in),
    .ir_out_o   (ir_out),
    .vs_cdr_i   (vs_cdr),
    .vs_sdr_i   (vs_sdr),
    .vs_udr_i   (vs_udr),
    .vs_cir_i   (vs_cir),
    .vs_uir_i   (vs_uir),
    .cap_data_i (cap_data),
    .upd_data_o (upd_data),
    .upd_ch_o   (upd_ch),
    .upd_vld_o  (upd_vld),
    .upd_ack_i  (upd_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ir(input logic [IR_W-1:0] code);
    ir_in = code; vs_uir = 1'b1; cyc(); vs_uir = 1'b0;
  endtask

  // Capture then shift nbits of bits LSB-first; tdo sampled just before each shift edge.
  task automatic cap_shift(input logic [63:0] bits, input int nbits);
    vs_cdr = 1'b1; cyc(); vs_cdr = 1'b0;
    seen = '0;
    for (int i = 0; i < nbits; i++) begin
      vs_sdr = 1'b1; tdi = bits[i];
      seen[i] = tdo;
      cyc();
    end
    vs_sdr = 1'b0; tdi = 1'b0;
  endtask

  task automatic udr();
    vs_udr = 1'b1; cyc(); vs_udr = 1'b0;
  endtask

  task automatic cir();
    vs_cir = 1'b1; cyc(); vs_cir = 1'b0;
  endtask

  task automatic ack();
    upd_ack = 1'b1; cyc(); upd_ack = 1'b0;
  endtask

  initial begin
    cap_data = {32'h3333_CCCC, 32'h2222_DDDD, 32'hA5A5_0F0F, 32'h0123_4567};
    cyc(); cyc();
    chk("rst_tdo", {63'd0, tdo}, 64'd0);
    chk("rst_ir_out", {60'd0, ir_out}, 64'd0);
    chk("rst_data", {32'd0, upd_data}, 64'd0);
    chk("rst_ch", {60'd0, upd_ch}, 64'd0);
    chk("rst_vld", {63'd0, upd_vld}, 64'd0);
    rst = 1'b0;
    cyc();

    // 1: full scan on channel 1
    set_ir(4'h1);
    cap_shift(64'h0000_0000_1234_5678, 32);
    chk("t1_tdo_stream", {32'd0, seen[31:0]}, 64'h0000_0000_A5A5_0F0F);
    udr();
    chk("t1_vld", {63'd0, upd_vld}, 64'd1);
    chk("t1_data", {32'd0, upd_data}, 64'h1234_5678);
    chk("t1_ch", {60'd0, upd_ch}, 64'd1);
    ack();
    chk("t1_ack_clears", {63'd0, upd_vld}, 64'd0);

    // 2: short scan flags short_err, cleared on capture
    set_ir(4'h2);
    cap_shift(64'h0000_0000_0000_BEEF, 16);
    udr();
    chk("t2_no_vld", {63'd0, upd_vld}, 64'd0);
    cir();
    chk("t2_cir1", {60'd0, ir_out}, 64'h4);
    cir();
    chk("t2_cir2", {60'd0, ir_out}, 64'h0);

    // 3: overrun when update not acked, then ack coinciding with UDR
    cap_shift(64'h0000_0000_DEAD_BEEF, 32);
    udr();
    set_ir(4'h3);
    cap_shift(64'h0000_0000_CAFE_F00D, 32);
    udr();
    chk("t3_held_data", {32'd0, upd_data}, 64'hDEAD_BEEF);
    chk("t3_held_ch", {60'd0, upd_ch}, 64'd2);
    cir();
    chk("t3_status", {60'd0, ir_out}, 64'h3);
    set_ir(4'h1);
    cap_shift(64'h0000_0000_0BAD_C0DE, 32);
    vs_udr = 1'b1; upd_ack = 1'b1; cyc(); vs_udr = 1'b0; upd_ack = 1'b0;
    chk("t3_ack_udr_vld", {63'd0, upd_vld}, 64'd1);
    chk("t3_ack_udr_data", {32'd0, upd_data}, 64'h0BAD_C0DE);
    chk("t3_ack_udr_ch", {60'd0, upd_ch}, 64'd1);
    cir();
    chk("t3_no_ovr", {60'd0, ir_out}, 64'h1);
    ack();

    // 4: bypass
    set_ir(4'hF);
    cap_shift(64'h0000_0000_0000_0005, 3);
    chk("t4_byp_tdo", {61'd0, seen[2:0]}, 64'h2);
    chk("t4_byp_last", {63'd0, tdo}, 64'd1);
    udr();
    chk("t4_no_upd", {63'd0, upd_vld}, 64'd0);
    cir();
    chk("t4_status", {60'd0, ir_out}, 64'h0);

    // 5: async reset mid-shift
    set_ir(4'h1);
    cap_shift(64'h0000_0000_FFFF_FFFF, 32);
    udr();
    cir();
    chk("t5_pre_status", {60'd0, ir_out}, 64'h1);
    cap_shift(64'h0000_0000_0000_03FF, 10);
    chk("t5_pre_tdo", {63'd0, tdo}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_tdo", {63'd0, tdo}, 64'd0);
    chk("t5_rst_ir_out", {60'd0, ir_out}, 64'd0);
    chk("t5_rst_data", {32'd0, upd_data}, 64'd0);
    chk("t5_rst_ch", {60'd0, upd_ch}, 64'd0);
    chk("t5_rst_vld", {63'd0, upd_vld}, 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    // bypass after reset: capture gives 0 and tdo follows tdi (ch 1 would give 1,1)
    cap_shift(64'h0, 1);
    chk("t5_byp_cap", {63'd0, seen[0]}, 64'd0);
    chk("t5_byp_shift", {63'd0, tdo}, 64'd0);
    udr();
    udr();
    cir();
    chk("t5_idle_udr_short", {60'd0, ir_out}, 64'h4);

    // 6: 40-bit scan on channel 0
    set_ir(4'h0);
    cap_shift(64'h0000_0089_ABCD_EF5A, 40);
    chk("t6_tdo_cap", {32'd0, seen[31:0]}, 64'h0123_4567);
    chk("t6_tdo_excess", {56'd0, seen[39:32]}, 64'h5A);
    udr();
    chk("t6_vld", {63'd0, upd_vld}, 64'd1);
    chk("t6_data", {32'd0, upd_data}, 64'h89AB_CDEF);
    chk("t6_ch", {60'd0, upd_ch}, 64'd0);
    cir();
    chk("t6_status", {60'd0, ir_out}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
